// File: rtl/tsl1401_sequencer.sv
// tsl1401_sequencer
// Drives the CLK and SI pins of a TSL1401-class linear CCD sensor (CJMCU-1401 board).
// Each frame has PIXELS readout periods, one flush period and integ_clks integration periods.
// During readout it emits one ADC sample strobe per pixel, together with the pixel index.
// Every output is registered. The pin drivers can therefore be packed into IOB flops.
`timescale 1ns/1ps

module tsl1401_sequencer #(
   parameter int HALF_DIV = 100,   // master cycles per sensor-clock half period
   parameter int PIXELS   = 128,   // pixels per line
   parameter int INTEG_W  = 16     // width of integ_clks
) (
   input  logic                      master_clock,
   input  logic                      master_reset_n,
   input  logic                      start,
   input  logic                      continuous,
   input  logic [INTEG_W-1:0]        integ_clks,
   output logic                      cjmcu1401_clk,
   output logic                      cjmcu1401_si,
   output logic                      sample_strobe,
   output logic [$clog2(PIXELS)-1:0] pixel_index,
   output logic                      frame_start,
   output logic                      frame_done,
   output logic                      busy
);

   localparam int IDX_W  = $clog2(PIXELS);
   // A one-bit counter is kept even when HALF_DIV=1. In that case it simply stays at 0.
   localparam int HALF_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
   // This is the longest possible frame, PIXELS + 1 + (2^INTEG_W - 1) periods.
   // The period counter is sized so that it can never wrap.
   localparam longint FRAME_MAX = longint'(PIXELS) + (longint'(1) << INTEG_W);
   localparam int PER_W  = $clog2(FRAME_MAX + 1);

   localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF_DIV - 1);
   localparam logic [PER_W-1:0]  PIX_P     = PER_W'(PIXELS);
   localparam logic [PER_W-1:0]  FLEN_BASE = PER_W'(PIXELS + 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FRAME = 1'b1
   } state_t;

   // Sequencer state
   state_t             state_reg, state_next;
   logic [HALF_W-1:0]  half_cnt_reg, half_cnt_next;
   logic               phase_reg, phase_next;
   logic [PER_W-1:0]   period_reg, period_next;
   logic [PER_W-1:0]   frame_len_reg, frame_len_next;

   // Registered outputs
   logic               clk_reg, clk_next;
   logic               si_reg, si_next;
   logic               strobe_reg, strobe_next;
   logic [IDX_W-1:0]   index_reg, index_next;
   logic               fstart_reg, fstart_next;
   logic               fdone_reg, fdone_next;
   logic               busy_reg, busy_next;

   // Decode of the current position
   logic               half_end;
   logic               period_end;
   logic               frame_end;
   logic               frame_begin;
   logic               in_frame_next;
   logic               last_cycle_next;

   assign half_end   = (half_cnt_reg == HALF_LAST);
   assign period_end = half_end && phase_reg;
   assign frame_end  = (state_reg == ST_FRAME) && period_end &&
                       (period_reg == frame_len_reg - 1'b1);

   // Next-state logic. The outputs for the following cycle are decoded from the next state,
   // so each registered output lines up exactly with the state it describes.
   always_comb begin
      state_next      = state_reg;
      half_cnt_next   = half_cnt_reg;
      phase_next      = phase_reg;
      period_next     = period_reg;
      frame_len_next  = frame_len_reg;
      frame_begin     = 1'b0;
      in_frame_next   = 1'b0;
      last_cycle_next = 1'b0;
      clk_next        = 1'b0;
      si_next         = 1'b0;
      strobe_next     = 1'b0;
      index_next      = index_reg;
      fstart_next     = 1'b0;
      fdone_next      = 1'b0;
      busy_next       = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            // start is honoured only here, so a pulse while busy has no effect
            if (start) begin
               state_next  = ST_FRAME;
               frame_begin = 1'b1;
            end
         end
         ST_FRAME: begin
            if (frame_end) begin
               // continuous is sampled only in the last cycle of the frame
               if (continuous) begin
                  frame_begin = 1'b1;
               end else begin
                  state_next    = ST_IDLE;
                  half_cnt_next = '0;
                  phase_next    = 1'b0;
                  period_next   = '0;
               end
            end else if (half_end) begin
               half_cnt_next = '0;
               if (phase_reg) begin
                  phase_next  = 1'b0;
                  period_next = period_reg + 1'b1;
               end else begin
                  phase_next  = 1'b1;
               end
            end else begin
               half_cnt_next = half_cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      // Every new frame begins at period 0, low half.
      // The frame length is latched here and holds for the whole frame.
      if (frame_begin) begin
         half_cnt_next  = '0;
         phase_next     = 1'b0;
         period_next    = '0;
         frame_len_next = FLEN_BASE + PER_W'(integ_clks);
      end

      in_frame_next   = (state_next == ST_FRAME);
      last_cycle_next = in_frame_next && phase_next && (half_cnt_next == HALF_LAST);

      clk_next    = in_frame_next && phase_next;
      // SI spans all of period 0 and falls together with CLK at the start of period 1
      si_next     = in_frame_next && (period_next == '0);
      // Sample in the last cycle of the high half, while AO has settled for this pixel
      strobe_next = last_cycle_next && (period_next < PIX_P);
      if (strobe_next) begin
         index_next = period_next[IDX_W-1:0];
      end
      fstart_next = frame_begin;
      fdone_next  = last_cycle_next && (period_next == frame_len_next - 1'b1);
      busy_next   = in_frame_next;
   end

   // State and output registers. Reset discards any partial frame immediately.
   always_ff @(posedge master_clock) begin
      if (!master_reset_n) begin
         state_reg     <= ST_IDLE;
         half_cnt_reg  <= '0;
         phase_reg     <= 1'b0;
         period_reg    <= '0;
         frame_len_reg <= '0;
         clk_reg       <= 1'b0;
         si_reg        <= 1'b0;
         strobe_reg    <= 1'b0;
         index_reg     <= '0;
         fstart_reg    <= 1'b0;
         fdone_reg     <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         half_cnt_reg  <= half_cnt_next;
         phase_reg     <= phase_next;
         period_reg    <= period_next;
         frame_len_reg <= frame_len_next;
         clk_reg       <= clk_next;
         si_reg        <= si_next;
         strobe_reg    <= strobe_next;
         index_reg     <= index_next;
         fstart_reg    <= fstart_next;
         fdone_reg     <= fdone_next;
         busy_reg      <= busy_next;
      end
   end

   assign cjmcu1401_clk = clk_reg;
   assign cjmcu1401_si  = si_reg;
   assign sample_strobe = strobe_reg;
   assign pixel_index   = index_reg;
   assign frame_start   = fstart_reg;
   assign frame_done    = fdone_reg;
   assign busy          = busy_reg;

endmodule

// File: tb/tb_tsl1401_sequencer.sv
// Testbench for tsl1401_sequencer.
// There are three instances: default parameters, a small one (HALF_DIV=3, PIXELS=8), and a minimal
// one (HALF_DIV=1, PIXELS=4). Expected strobe and frame events go into a queue when a start is driven.
// Expected frame windows give the CLK/SI/busy waveform for every cycle.
`timescale 1ns/1ps

module tb_tsl1401_sequencer;

   localparam int NI = 3;

   logic          master_clock = 1'b0;
   logic          master_reset_n;
   logic [NI-1:0] start_v, cont_v;
   logic [NI-1:0] clk_v, si_v, stb_v, fs_v, fd_v, busy_v;
   logic [15:0]   integ0;
   logic [7:0]    integ1;
   logic [3:0]    integ2;
   logic [6:0]    idx0;
   logic [2:0]    idx1;
   logic [1:0]    idx2;

   typedef struct { int inst; int kind; int cyc; int idx; } ev_t;   // kind 0=start 1=strobe 2=done
   typedef struct { int inst; int s; int len; } fr_t;

   ev_t evq[$];
   fr_t frq[$];
   int  cyc   = 0;
   int  total = 0;
   int  bad   = 0;
   bit  chk_en = 1'b0;

   always #5 master_clock = ~master_clock;

   tsl1401_sequencer #(.HALF_DIV(100), .PIXELS(128), .INTEG_W(16)) u_dut0 (
      .master_clock(master_clock), .master_reset_n(master_reset_n),
      .start(start_v[0]), .continuous(cont_v[0]), .integ_clks(integ0),
      .cjmcu1401_clk(clk_v[0]), .cjmcu1401_si(si_v[0]), .sample_strobe(stb_v[0]),
      .pixel_index(idx0), .frame_start(fs_v[0]), .frame_done(fd_v[0]), .busy(busy_v[0]));

   tsl1401_sequencer #(.HALF_DIV(3), .PIXELS(8), .INTEG_W(8)) u_dut1 (
      .master_clock(master_clock), .master_reset_n(master_reset_n),
      .start(start_v[1]), .continuous(cont_v[1]), .integ_clks(integ1),
      .cjmcu1401_clk(clk_v[1]), .cjmcu1401_si(si_v[1]), .sample_strobe(stb_v[1]),
      .pixel_index(idx1), .frame_start(fs_v[1]), .frame_done(fd_v[1]), .busy(busy_v[1]));

   tsl1401_sequencer #(.HALF_DIV(1), .PIXELS(4), .INTEG_W(4)) u_dut2 (
      .master_clock(master_clock), .master_reset_n(master_reset_n),
      .start(start_v[2]), .continuous(cont_v[2]), .integ_clks(integ2),
      .cjmcu1401_clk(clk_v[2]), .cjmcu1401_si(si_v[2]), .sample_strobe(stb_v[2]),
      .pixel_index(idx2), .frame_start(fs_v[2]), .frame_done(fd_v[2]), .busy(busy_v[2]));

   function automatic int hdiv(input int i);
      case (i)
         0:       return 100;
         1:       return 3;
         default: return 1;
      endcase
   endfunction

   function automatic int pix(input int i);
      case (i)
         0:       return 128;
         1:       return 8;
         default: return 4;
      endcase
   endfunction

   function automatic logic [31:0] get_idx(input int i);
      case (i)
         0:       return {25'b0, idx0};
         1:       return {29'b0, idx1};
         default: return {30'b0, idx2};
      endcase
   endfunction

   // Queue the events of one frame that starts at cycle s; returns the first cycle after it
   function automatic int push_frame(input int i, input int s, input int integ);
      int h   = hdiv(i);
      int p   = pix(i);
      int len = 2 * h * (p + 1 + integ);
      frq.push_back('{i, s, len});
      evq.push_back('{i, 0, s, 0});
      for (int n = 0; n < p; n++) evq.push_back('{i, 1, s + 2*h*n + 2*h - 1, n});
      evq.push_back('{i, 2, s + len - 1, 0});
      return s + len;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic check_ev(input int i, input int k);
      ev_t e;
      if (evq.size() == 0) e = '{-1, -1, -1, -1};
      else                 e = evq.pop_front();
      total++;
      assert ((i === e.inst) && (k === e.kind) && (cyc === e.cyc)) else begin
         bad++;
         $error("FAIL event: got inst=%0d kind=%0d cyc=%0d expected inst=%0d kind=%0d cyc=%0d",
                i, k, cyc, e.inst, e.kind, e.cyc);
      end
      if (k == 1) begin
         total++;
         assert (get_idx(i) === 32'(e.idx)) else begin
            bad++;
            $error("FAIL strobe_idx inst%0d cyc=%0d: got %0d expected %0d", i, cyc, get_idx(i), e.idx);
         end
      end
   endtask

   task automatic check_wave(input int i);
      logic [2:0] expv, obsv;
      int off, h;
      expv = 3'b000;
      h    = hdiv(i);
      foreach (frq[j]) begin
         if (frq[j].inst == i && cyc >= frq[j].s && cyc < frq[j].s + frq[j].len) begin
            off  = cyc - frq[j].s;
            expv = {1'b1, ((off / h) % 2) == 1, off < 2*h};
         end
      end
      obsv = {busy_v[i], clk_v[i], si_v[i]};
      total++;
      assert (obsv === expv) else begin
         bad++;
         $error("FAIL wave inst%0d cyc=%0d busy/clk/si: got %b expected %b", i, cyc, obsv, expv);
      end
   endtask

   // One master cycle: check outputs on the falling edge, then advance past the rising edge
   task automatic tick();
      @(negedge master_clock);
      if (chk_en) begin
         for (int i = 0; i < NI; i++) begin
            check_wave(i);
            if (fs_v[i])  check_ev(i, 0);
            if (stb_v[i]) check_ev(i, 1);
            if (fd_v[i])  check_ev(i, 2);
         end
      end
      @(posedge master_clock);
      cyc++;
      #1;
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) tick();
   endtask

   task automatic pulse(input int i);
      start_v[i] = 1'b1;
      tick();
      start_v[i] = 1'b0;
   endtask

   // Reset is sampled at the end of the current cycle.
   // Expectations beyond that cycle are dropped.
   task automatic do_reset();
      ev_t keep[$];
      fr_t fk[$];
      fr_t f;
      int  r;
      r = cyc;
      master_reset_n = 1'b0;
      foreach (evq[j]) if (evq[j].cyc <= r) keep.push_back(evq[j]);
      evq = keep;
      foreach (frq[j]) begin
         if (frq[j].s <= r) begin
            f = frq[j];
            if (f.s + f.len > r + 1) f.len = r + 1 - f.s;
            fk.push_back(f);
         end
      end
      frq = fk;
      tick();
      master_reset_n = 1'b1;
   endtask

   initial begin
      int s, a, b, e;
      master_reset_n = 1'b0;
      start_v = '0;
      cont_v  = '0;
      integ0  = '0;
      integ1  = '0;
      integ2  = '0;
      repeat (3) tick();
      chk("reset_outputs", {14'b0, clk_v, si_v, stb_v, fs_v, fd_v, busy_v}, 32'd0);
      chk("reset_index", {20'b0, idx0, idx1, idx2}, 32'd0);
      master_reset_n = 1'b1;
      chk_en = 1'b1;

      // Default timing, single shot, integ=0: frame of 25800 cycles
      s = cyc + 1;
      e = push_frame(0, s, 0);
      pulse(0);
      wait_cyc(e + 4);
      chk("t1_idx_hold", get_idx(0), 32'd127);
      chk("t1_busy_low", {31'b0, busy_v[0]}, 32'd0);
      chk("t1_queue_empty", evq.size(), 32'd0);

      // Continuous with integ=10; continuous dropped inside the third frame
      integ1    = 8'd10;
      cont_v[1] = 1'b1;
      s = cyc + 1;
      a = push_frame(1, s, 10);
      b = push_frame(1, a, 10);
      e = push_frame(1, b, 10);
      pulse(1);
      wait_cyc(b + 50);
      cont_v[1] = 1'b0;
      wait_cyc(e + 4);
      chk("t2_queue_empty", evq.size(), 32'd0);
      chk("t2_idx_hold", get_idx(1), 32'd7);

      // Start pulses while busy: at strobe 5, during flush, on the frame_done cycle
      integ1 = 8'd2;
      s = cyc + 1;
      e = push_frame(1, s, 2);
      pulse(1);
      wait_cyc(s + 35);
      pulse(1);
      wait_cyc(s + 50);
      pulse(1);
      wait_cyc(e - 1);
      pulse(1);
      wait_cyc(e + 4);
      chk("t3_queue_empty", evq.size(), 32'd0);

      // Reset at pixel 5, then a clean frame
      integ1 = 8'd0;
      s = cyc + 1;
      e = push_frame(1, s, 0);
      pulse(1);
      wait_cyc(s + 35);
      chk("t4_idx_before_reset", get_idx(1), 32'd5);
      do_reset();
      chk("t4_reset_outputs", {26'b0, clk_v[1], si_v[1], stb_v[1], fs_v[1], fd_v[1], busy_v[1]}, 32'd0);
      chk("t4_reset_index", get_idx(1), 32'd0);
      chk("t4_queue_empty", evq.size(), 32'd0);
      tick();
      s = cyc + 1;
      e = push_frame(1, s, 0);
      pulse(1);
      wait_cyc(e + 4);
      chk("t4_clean_frame", evq.size(), 32'd0);

      // integ_clks changed mid-frame in continuous mode: 9 periods, then 14 periods
      cont_v[1] = 1'b1;
      s = cyc + 1;
      a = push_frame(1, s, 0);
      e = push_frame(1, a, 5);
      pulse(1);
      wait_cyc(s + 20);
      integ1 = 8'd5;
      wait_cyc(a + 30);
      cont_v[1] = 1'b0;
      wait_cyc(e + 4);
      chk("t6_queue_empty", evq.size(), 32'd0);

      // HALF_DIV=1, PIXELS=4, integ=2: 14-cycle frame
      integ2 = 4'd2;
      s = cyc + 1;
      e = push_frame(2, s, 2);
      pulse(2);
      wait_cyc(e + 3);
      chk("t5_queue_empty", evq.size(), 32'd0);
      chk("t5_idx_hold", get_idx(2), 32'd3);

      // Minimal instance, continuous with integ=0: two back-to-back 10-cycle frames
      integ2    = 4'd0;
      cont_v[2] = 1'b1;
      s = cyc + 1;
      a = push_frame(2, s, 0);
      e = push_frame(2, a, 0);
      pulse(2);
      wait_cyc(a + 2);
      cont_v[2] = 1'b0;
      wait_cyc(e + 3);
      chk("t5b_queue_empty", evq.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
